// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC register, icache request and IF/ID latch
// Redirects that arrive mid-miss are parked in pend_pc until the outstanding fetch returns.
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_npc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pend_pc;
    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_ifpc;
    logic [31:0] r_npc;

    logic [31:0] w_redirect;
    logic [31:0] w_pc_plus4;

    assign w_redirect = redirect_pc & ~32'd3;
    assign w_pc_plus4 = r_pc + 32'd4;

    // Request is gated by RST directly so it drops in the very cycle reset is raised.
    assign imemREN    = !RST && (r_state != IDLE);
    assign imemaddr   = r_pc;
    assign ifid_valid = r_valid;
    assign ifid_instr = r_instr;
    assign ifid_pc    = r_ifpc;
    assign ifid_npc   = r_npc;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_pc      <= PC_INIT;
            r_pend_pc <= 32'd0;
            r_valid   <= 1'b0;
            r_instr   <= 32'd0;
            r_ifpc    <= 32'd0;
            r_npc     <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= FETCH;
                end
                FETCH: begin
                    if (flush) begin
                        r_valid <= 1'b0;
                        if (ihit) begin
                            r_pc <= w_redirect;
                        end else begin
                            r_pend_pc <= w_redirect;
                            r_state   <= DRAIN;
                        end
                    end else if (ihit) begin
                        if (!stall) begin
                            r_valid <= 1'b1;
                            r_instr <= imemload;
                            r_ifpc  <= r_pc;
                            r_npc   <= w_pc_plus4;
                            r_pc    <= w_pc_plus4;
                        end
                    end else if (!stall) begin
                        r_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    // The in-flight word belongs to the squashed path; only its completion matters.
                    r_valid <= 1'b0;
                    if (flush) begin
                        r_pend_pc <= w_redirect;
                    end
                    if (ihit) begin
                        r_pc    <= flush ? w_redirect : r_pend_pc;
                        r_state <= FETCH;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage against a behavioural model
module tb_fetch_stage;

    logic        CLK;
    logic        RST;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        ihit;
    logic [31:0] imemload;

    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_npc;

    logic        d2_ren;
    logic [31:0] d2_addr;
    logic        d2_valid;
    logic [31:0] d2_instr;
    logic [31:0] d2_pc;
    logic [31:0] d2_npc;

    int n_cmp;
    int n_bad;

    fetch_stage dut (
        .CLK(CLK), .RST(RST), .flush(flush), .redirect_pc(redirect_pc), .stall(stall),
        .imemREN(imemREN), .imemaddr(imemaddr), .ihit(ihit), .imemload(imemload),
        .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_npc(ifid_npc)
    );

    fetch_stage #(.PC_INIT(32'hFFFF_FFFC)) dut2 (
        .CLK(CLK), .RST(RST), .flush(flush), .redirect_pc(redirect_pc), .stall(stall),
        .imemREN(d2_ren), .imemaddr(d2_addr), .ihit(ihit), .imemload(imemload),
        .ifid_valid(d2_valid), .ifid_instr(d2_instr), .ifid_pc(d2_pc), .ifid_npc(d2_npc)
    );

    // icache contents: each word tags its own address
    assign imemload = {16'hC0DE, imemaddr[15:0]};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: started = past the post-reset idle cycle, waiting = redirect parked.
    logic        m_known;
    logic        m_started;
    logic        m_waiting;
    logic [31:0] m_pc;
    logic [31:0] m_pend;
    logic        m_v;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic [31:0] m_npc;
    logic [31:0] m_tgt;
    logic [31:0] m_newest;

    assign m_tgt    = {redirect_pc[31:2], 2'b00};
    assign m_newest = flush ? m_tgt : m_pend;

    initial begin
        m_known   = 1'b0;
        m_started = 1'b0;
        m_waiting = 1'b0;
    end

    always @(posedge CLK) begin
        if (RST) begin
            m_known   <= 1'b1;
            m_started <= 1'b0;
            m_waiting <= 1'b0;
            m_pc      <= 32'd0;
            m_pend    <= 32'd0;
            m_v       <= 1'b0;
            m_instr   <= 32'd0;
            m_ipc     <= 32'd0;
            m_npc     <= 32'd0;
        end else if (!m_started) begin
            m_started <= 1'b1;
        end else if (m_waiting) begin
            m_v    <= 1'b0;
            m_pend <= m_newest;
            if (ihit) begin
                m_pc      <= m_newest;
                m_waiting <= 1'b0;
            end
        end else if (flush) begin
            m_v <= 1'b0;
            if (ihit) begin
                m_pc <= m_tgt;
            end else begin
                m_pend    <= m_tgt;
                m_waiting <= 1'b1;
            end
        end else if (ihit && !stall) begin
            m_v     <= 1'b1;
            m_instr <= {16'hC0DE, m_pc[15:0]};
            m_ipc   <= m_pc;
            m_npc   <= m_pc + 32'd4;
            m_pc    <= m_pc + 32'd4;
        end else if (!ihit && !stall) begin
            m_v <= 1'b0;
        end
    end

    always @(negedge CLK) begin
        if (m_known) begin
            chk("imemREN", {31'd0, imemREN}, {31'd0, !RST && m_started});
            if (!RST && m_started) chk("imemaddr", imemaddr, m_pc);
            chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_v});
            chk("ifid_instr", ifid_instr, m_instr);
            chk("ifid_pc", ifid_pc, m_ipc);
            chk("ifid_npc", ifid_npc, m_npc);
        end
    end

    task automatic step(input logic r, input logic f, input logic [31:0] rp,
                        input logic s, input logic h);
        @(posedge CLK);
        #2;
        RST = r; flush = f; redirect_pc = rp; stall = s; ihit = h;
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        RST = 1'b1; flush = 1'b0; redirect_pc = 32'd0; stall = 1'b0; ihit = 1'b0;

        step(1, 0, 0, 0, 0);
        chk("rst_ren", {31'd0, imemREN}, 32'd0);
        chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
        chk("rst_pc", imemaddr, 32'd0);
        chk("rst_pc2", d2_addr, 32'hFFFF_FFFC);
        step(0, 1, 32'h900, 0, 1);
        chk("idle_ren", {31'd0, imemREN}, 32'd0);
        step(0, 0, 0, 0, 1);
        chk("first_ren", {31'd0, imemREN}, 32'd1);
        chk("first_addr", imemaddr, 32'd0);
        chk("first_addr2", d2_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 1);
        chk("seq_addr4", imemaddr, 32'd4);
        chk("seq_ifpc0", ifid_pc, 32'd0);
        chk("seq_npc4", ifid_npc, 32'd4);
        chk("seq_instr0", ifid_instr, 32'hC0DE_0000);
        chk("wrap_npc", d2_npc, 32'd0);
        chk("wrap_ifpc", d2_pc, 32'hFFFF_FFFC);
        chk("wrap_addr", d2_addr, 32'd0);
        step(0, 0, 0, 0, 1);
        chk("seq_addr8", imemaddr, 32'd8);
        chk("seq_ifpc4", ifid_pc, 32'd4);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("bubble_valid", {31'd0, ifid_valid}, 32'd0);
        chk("bubble_pc", ifid_pc, 32'd8);
        chk("bubble_addr", imemaddr, 32'hC);

        step(0, 1, 32'h40, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 1);
            chk("stall_addr", imemaddr, 32'h40);
        end
        step(0, 0, 0, 0, 1);
        chk("stall_addr4", imemaddr, 32'h40);
        step(0, 0, 0, 0, 0);
        chk("stall_next", imemaddr, 32'h44);
        chk("stall_ifpc", ifid_pc, 32'h40);
        step(0, 0, 0, 0, 0);

        step(0, 1, 32'h80, 0, 1);
        step(0, 1, 32'h203, 0, 0);
        chk("drain_addr0", imemaddr, 32'h80);
        step(0, 0, 0, 1, 0);
        chk("drain_addr1", imemaddr, 32'h80);
        chk("drain_valid", {31'd0, ifid_valid}, 32'd0);
        step(0, 0, 0, 0, 1);
        chk("drain_addr2", imemaddr, 32'h80);
        step(0, 0, 0, 0, 0);
        chk("drain_next", imemaddr, 32'h200);
        chk("drain_valid2", {31'd0, ifid_valid}, 32'd0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        chk("drain_latch", ifid_pc, 32'h200);

        step(0, 1, 32'h200, 0, 0);
        step(0, 1, 32'h300, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        chk("newest_wins", imemaddr, 32'h300);
        step(0, 1, 32'h400, 0, 0);
        step(0, 1, 32'h444, 0, 1);
        step(0, 0, 0, 0, 0);
        chk("same_cycle_redirect", imemaddr, 32'h444);

        step(0, 1, 32'hC, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 1, 32'h100, 1, 1);
        chk("fs_valid_before", {31'd0, ifid_valid}, 32'd1);
        step(0, 0, 0, 0, 0);
        chk("fs_valid", {31'd0, ifid_valid}, 32'd0);
        chk("fs_addr", imemaddr, 32'h100);

        step(0, 1, 32'h500, 0, 0);
        step(1, 0, 0, 0, 1);
        chk("rst_drain_ren", {31'd0, imemREN}, 32'd0);
        step(0, 1, 32'h700, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("rst_abandon", imemaddr, 32'd0);
        step(0, 0, 0, 0, 0);
        chk("rst_abandon_pc", ifid_pc, 32'd0);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 5) == 0),
                 $urandom, ($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1);
        end
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        @(posedge CLK);
        @(negedge CLK);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
